trigger_capture_ctrl: RTL and testbench
=======================================

TRIGGER_CAPTURE_CTRL -- requirements
Module: trigger_capture_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8: depth of the downstream capture shift register in samples; legal range is 2 or more.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: sample width in bits.
REQ-003 SHALL have local CW = $clog2(SIZE+1): the width of the post-count and internal counters.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 i_clk  in  1  clock; all logic on rising edge.
REQ-006 i_rst_n  in  1  synchronous active-low reset.
REQ-007 i_sample_valid  in  1  one-cycle strobe: a new ADC sample is present.
REQ-008 i_sample  in  DATA_WIDTH  unsigned ADC sample.
REQ-009 i_arm  in  1  request to start a capture.
REQ-010 i_ack  in  1  readout finished; release the buffer.
REQ-011 i_level  in  DATA_WIDTH  unsigned trigger threshold.
REQ-012 i_rising  in  1  edge select: 1 = rising, 0 = falling.
REQ-013 i_post_count  in  CW  post-trigger samples P, counting the trigger sample itself.
REQ-014 o_push  out  1  push strobe to the shift register.
REQ-015 o_push_data  out  DATA_WIDTH  sample delivered with o_push.
REQ-016 o_busy  out  1  high in PREFILL, ARMED and POST.
REQ-017 o_triggered  out  1  high in POST and DONE.
REQ-018 o_done  out  1  high in DONE; buffer frozen and valid.

Function
REQ-019 SHALL implement states IDLE, PREFILL, ARMED, POST and DONE.
REQ-020 SHALL latch i_post_count on the accepted arm as P_eff, computed as follows:
- 0 maps to 1;
- values above SIZE map to SIZE;
- pretrigger count PRE = SIZE - P_eff.
REQ-021 SHALL accept i_arm only in IDLE or DONE:
- target state is PREFILL when PRE > 0;
- target state is ARMED when PRE = 0;
- i_arm in any other state is ignored.
REQ-022 SHALL, in PREFILL/ARMED/POST, register each valid sample to o_push=1, o_push_data=i_sample one cycle later; no pushes occur in IDLE or DONE.
REQ-023 SHALL, in PREFILL, count pushed samples and move to ARMED on the cycle the PRE-th sample is accepted; PREFILL samples never trigger.
REQ-024 SHALL hold prev_sample plus a prev_valid flag:
- prev_sample updates on every valid sample in PREFILL/ARMED/POST;
- prev_valid clears on accepted arm and sets on the first subsequent valid sample.
REQ-025 SHALL detect the trigger in ARMED on a valid sample with prev_valid=1:
- rising: prev_sample < i_level and i_sample >= i_level;
- falling: prev_sample > i_level and i_sample <= i_level.
REQ-026 SHALL push the trigger sample, then go to DONE if P_eff = 1, otherwise to POST with remaining count P_eff - 1.
REQ-027 SHALL, in POST, decrement the remaining count per accepted sample and enter DONE on the sample that brings it to 0.
REQ-028 SHALL assert o_done in the same cycle as the o_push of the final sample, so that exactly SIZE samples have been pushed since arm: PRE before the trigger sample, the trigger sample, and P_eff - 1 after it.
REQ-029 SHALL, in DONE, return to IDLE on i_ack; i_arm together with i_ack re-arms, and arm takes priority.
REQ-030 SHALL compare i_level and i_rising live, every cycle; they are not latched.

Reset
REQ-031 SHALL, with i_rst_n=0 at a clock edge, force:
- state to IDLE;
- o_push=0 and o_push_data=0;
- o_busy=0, o_triggered=0, o_done=0;
- all counters and prev_sample to 0, prev_valid to 0.
REQ-032 SHALL abort any capture in progress when reset is applied mid-capture; the first post-reset cycle has no push and ignores i_sample_valid.

Configuration
REQ-033 SHALL support macro FORCE_TRIGGER_EN.
- Defined: adds input i_force (1 bit); a valid sample in ARMED with i_force=1 is treated as the trigger regardless of level, edge or prev_valid.
- Undefined: port i_force is absent and only level/edge triggering exists.
- All other behaviour is identical either way.

Verification
REQ-034 SIZE=8, post=4, rising, level=0x80, samples 0x10,0x20,... -> 4 prefill pushes then ARMED; 0x70 then 0x90 triggers; o_done after 3 more pushes; total 8 pushes.
REQ-035 post=0 -> P_eff=1, PRE=7; trigger sample push and o_done occur on the same cycle; no POST state visited.
REQ-036 post=8, falling, level=0x40, samples 0x50 then 0x30 -> no PREFILL; 0x30 triggers; 7 further pushes, then DONE; post=15 behaves identically.
REQ-037 In DONE, i_arm and i_ack together -> next state is PREFILL, o_done=0, and the first following sample cannot trigger because prev_valid=0.
REQ-038 i_rst_n=0 during POST with 2 samples remaining -> all outputs 0 and state IDLE the next cycle; the bench then checks that i_arm is accepted.
REQ-039 With FORCE_TRIGGER_EN, ARMED state, constant sample 0x00, and i_force=1 on a valid sample -> trigger taken and POST entered.

Source files
------------

// File: rtl/trigger_capture_ctrl.sv
// rtl/trigger_capture_ctrl.sv - pre/post-trigger capture controller feeding a SIZE-deep shift register
// Optional macro FORCE_TRIGGER_EN adds i_force to take the trigger on any valid ARMED sample.
module trigger_capture_ctrl #(
  parameter  int SIZE       = 8,
  parameter  int DATA_WIDTH = 8,
  localparam int CW         = $clog2(SIZE + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sample_valid,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_arm,
`ifdef FORCE_TRIGGER_EN
  input  logic                  i_force,
`endif
  input  logic                  i_ack,
  input  logic [DATA_WIDTH-1:0] i_level,
  input  logic                  i_rising,
  input  logic [CW-1:0]         i_post_count,
  output logic                  o_push,
  output logic [DATA_WIDTH-1:0] o_push_data,
  output logic                  o_busy,
  output logic                  o_triggered,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         peff_q, peff_d;
  logic [DATA_WIDTH-1:0] prev_sample_q, prev_sample_d;
  logic                  prev_valid_q, prev_valid_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] push_data_q, push_data_d;

  logic [CW-1:0] peff_arm;
  logic [CW-1:0] pre_arm;
  logic          arm_ok;
  logic          capturing;
  logic          level_hit;
  logic          trig_hit;

  always_comb begin
    peff_arm = i_post_count;
    if (i_post_count == '0) begin
      peff_arm = ONE_C;
    end else if (i_post_count > SIZE_C) begin
      peff_arm = SIZE_C;
    end
  end

  assign pre_arm   = SIZE_C - peff_arm;
  assign arm_ok    = i_arm && (state_q == S_IDLE || state_q == S_DONE);
  assign capturing = (state_q == S_PREFILL) || (state_q == S_ARMED) || (state_q == S_POST);

  // Threshold and edge are live inputs; only the previous sample is remembered.
  assign level_hit = i_rising ? ((prev_sample_q < i_level) && (i_sample >= i_level))
                              : ((prev_sample_q > i_level) && (i_sample <= i_level));
`ifdef FORCE_TRIGGER_EN
  assign trig_hit  = (prev_valid_q && level_hit) || i_force;
`else
  assign trig_hit  = prev_valid_q && level_hit;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    peff_d        = peff_q;
    prev_sample_d = prev_sample_q;
    prev_valid_d  = prev_valid_q;
    push_d        = 1'b0;
    push_data_d   = push_data_q;

    if (arm_ok) begin
      peff_d       = peff_arm;
      prev_valid_d = 1'b0;
      if (pre_arm != '0) begin
        state_d = S_PREFILL;
        cnt_d   = pre_arm;
      end else begin
        state_d = S_ARMED;
        cnt_d   = '0;
      end
    end else if (i_sample_valid && capturing) begin
      push_d        = 1'b1;
      push_data_d   = i_sample;
      prev_sample_d = i_sample;
      prev_valid_d  = 1'b1;
      case (state_q)
        S_PREFILL: begin
          cnt_d = cnt_q - ONE_C;
          if (cnt_q == ONE_C) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_hit) begin
            // The trigger sample itself is the first of the P_eff post samples.
            if (peff_q == ONE_C) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end else begin
              state_d = S_POST;
              cnt_d   = peff_q - ONE_C;
            end
          end
        end
        S_POST: begin
          cnt_d = cnt_q - ONE_C;
          if (cnt_q == ONE_C) begin
            state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end else if (state_q == S_DONE && i_ack) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      peff_q        <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      push_q        <= 1'b0;
      push_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      peff_q        <= peff_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      push_q        <= push_d;
      push_data_q   <= push_data_d;
    end
  end

  assign o_push      = push_q;
  assign o_push_data = push_data_q;
  assign o_busy      = capturing;
  assign o_triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// tb/tb_trigger_capture_ctrl.sv - scoreboard bench for trigger_capture_ctrl
module tb_trigger_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sample;
  logic       arm;
  logic       ack;
  logic [7:0] level;
  logic       rising;
  logic [3:0] post_count;
  logic       push;
  logic [7:0] push_data;
  logic       busy;
  logic       triggered;
  logic       done;
`ifdef FORCE_TRIGGER_EN
  logic       force_trig;
`endif

  always #5 clk = ~clk;

  trigger_capture_ctrl #(.SIZE(8), .DATA_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_valid (sample_valid),
    .i_sample       (sample),
    .i_arm          (arm),
`ifdef FORCE_TRIGGER_EN
    .i_force        (force_trig),
`endif
    .i_ack          (ack),
    .i_level        (level),
    .i_rising       (rising),
    .i_post_count   (post_count),
    .o_push         (push),
    .o_push_data    (push_data),
    .o_busy         (busy),
    .o_triggered    (triggered),
    .o_done         (done)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       done;
    logic       trig;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Monitor: every push is matched against the next expected record.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (push === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_push", {24'd0, push_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("push_data", {24'd0, push_data}, {24'd0, e.data});
        chk("push_done", {31'd0, done}, {31'd0, e.done});
        chk("push_trig", {31'd0, triggered}, {31'd0, e.trig});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input bit pushed, input bit e_done, input bit e_trig);
    exp_t e;
    if (pushed) begin
      e.data = v;
      e.done = e_done;
      e.trig = e_trig;
      exp_q.push_back(e);
    end
    sample_valid = 1'b1;
    sample       = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [3:0] p, input bit rise, input logic [7:0] lvl, input bit with_ack);
    post_count = p;
    rising     = rise;
    level      = lvl;
    arm        = 1'b1;
    ack        = with_ack;
    tick();
    arm        = 1'b0;
    ack        = 1'b0;
  endtask

  task automatic chk_state(input string name, input bit b, input bit t, input bit d);
    chk(name, {29'd0, busy, triggered, done}, {29'd0, b, t, d});
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample       = 8'h00;
    arm          = 1'b0;
    ack          = 1'b0;
    level        = 8'h80;
    rising       = 1'b1;
    post_count   = 4'd4;
`ifdef FORCE_TRIGGER_EN
    force_trig   = 1'b0;
`endif
    tick();
    tick();
    chk("reset_outputs", {20'd0, push, push_data, busy, triggered, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    send(8'h55, 0, 0, 0);
    chk_state("idle_no_capture", 0, 0, 0);

    // Capture 1: post=4 rising at 0x80; 4 prefill, trigger, 3 post.
    do_arm(4'd4, 1, 8'h80, 0);
    chk_state("arm_prefill", 1, 0, 0);
    send(8'h10, 1, 0, 0);
    send(8'h20, 1, 0, 0);
    send(8'h30, 1, 0, 0);
    send(8'h70, 1, 0, 0);
    chk_state("armed_after_prefill", 1, 0, 0);
    post_count = 4'd0;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    send(8'h90, 1, 0, 1);
    chk_state("post_after_trigger", 1, 1, 0);
    send(8'hA0, 1, 0, 1);
    send(8'hB0, 1, 0, 1);
    send(8'hC0, 1, 1, 1);
    chk_state("done_1", 0, 1, 1);
    send(8'hD0, 0, 0, 0);
    chk_state("done_holds", 0, 1, 1);

    // Arm+ack in DONE, post=8 falling: straight to ARMED, stale prev must not trigger.
    do_arm(4'd8, 0, 8'h40, 1);
    chk_state("rearm_armed", 1, 0, 0);
    send(8'h30, 1, 0, 0);
    chk_state("no_trig_prev_invalid", 1, 0, 0);
    send(8'h50, 1, 0, 0);
    send(8'h30, 1, 0, 1);
    for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), 1, 0, 1);
    send(8'h2F, 1, 1, 1);
    chk_state("done_2", 0, 1, 1);

    // Arm alone in DONE, post=15 clamps to 8.
    do_arm(4'd15, 0, 8'h40, 0);
    chk_state("clamp_armed", 1, 0, 0);
    send(8'h50, 1, 0, 0);
    send(8'h30, 1, 0, 1);
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 1, 0, 1);
    send(8'h1F, 1, 1, 1);
    chk_state("done_3", 0, 1, 1);

    // Arm+ack with post=0: PRE=7, prefill edge ignored, trigger equals final sample.
    do_arm(4'd0, 1, 8'h80, 1);
    chk_state("rearm_prefill", 1, 0, 0);
    send(8'h01, 1, 0, 0);
    send(8'h02, 1, 0, 0);
    send(8'h7F, 1, 0, 0);
    send(8'h90, 1, 0, 0);
    send(8'h10, 1, 0, 0);
    send(8'h20, 1, 0, 0);
    send(8'h7F, 1, 0, 0);
    send(8'h80, 1, 1, 1);
    chk_state("done_4", 0, 1, 1);

    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_state("ack_idle", 0, 0, 0);

    // Reset during POST with 2 samples remaining.
    do_arm(4'd4, 1, 8'h80, 0);
    send(8'h10, 1, 0, 0);
    send(8'h20, 1, 0, 0);
    send(8'h30, 1, 0, 0);
    send(8'h70, 1, 0, 0);
    send(8'h90, 1, 0, 1);
    send(8'hA0, 1, 0, 1);
    rst_n        = 1'b0;
    sample_valid = 1'b1;
    sample       = 8'hB0;
    tick();
    chk("midreset_outputs", {20'd0, push, push_data, busy, triggered, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("post_reset_no_push", {20'd0, push, push_data, busy, triggered, done}, 32'd0);
    do_arm(4'd8, 1, 8'h80, 0);
    chk_state("arm_after_reset", 1, 0, 0);

`ifdef FORCE_TRIGGER_EN
    send(8'h00, 1, 0, 0);
    force_trig = 1'b1;
    send(8'h00, 1, 0, 1);
    force_trig = 1'b0;
    chk_state("force_post", 1, 1, 0);
`endif

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
